// File: rtl/if_id_skid_stage_if.sv
// Valid/ready bundle carrying instruction + PC from fetch, through the IF/ID stage, to decode.
interface if_id_skid_stage_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instruction;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instruction;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output in_valid, in_instruction, in_pc, out_ready,
        input  in_ready, out_valid, out_instruction, out_pc
    );

    modport slave (
        input  in_valid, in_instruction, in_pc, out_ready,
        output in_ready, out_valid, out_instruction, out_pc
    );
endinterface

// File: rtl/if_id_skid_stage.sv
// IF/ID stage register with a 2-entry skid buffer, BUSYWAIT freeze and FLUSH bubble.
// Optional perf counters (stall_cycles, flush_count) are built when IF_ID_PERF_CNT_EN is defined.
module if_id_skid_stage #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013),
    parameter int                 CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 busywait,
    input  logic                 flush,
    if_id_skid_stage_if.slave    bus
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
`endif
);

    // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b10,
        SKID  = 2'b11
    } state_t;

    state_t state, state_n;

    logic               out_valid;
    logic               skid_valid;
    logic               in_ready;
    logic               in_fire;
    logic               out_fire;
    logic               ld_out_in;
    logic               ld_out_skid;
    logic               ld_skid;

    logic [INSTR_W-1:0] skid_instr_p0;
    logic [PC_W-1:0]    skid_pc_p0;
    logic [INSTR_W-1:0] out_instr_p1;
    logic [PC_W-1:0]    out_pc_p1;

    assign out_valid  = state[1];
    assign skid_valid = state[0];
    assign in_ready   = ~skid_valid & ~busywait;
    assign in_fire    = bus.in_valid & in_ready & ~flush;
    assign out_fire   = out_valid & bus.out_ready & ~busywait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        ld_out_in   = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_n   = FULL;
                        ld_out_in = 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        ld_out_in = 1'b1;
                    end else if (in_fire) begin
                        state_n = SKID;
                        ld_skid = 1'b1;
                    end else if (out_fire) begin
                        state_n = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_n     = FULL;
                        ld_out_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // Stage boundary: fetch side -> skid (p0) -> decode-facing register (p1).
    always_ff @(posedge clk) begin
        if (ld_out_in) begin
            out_instr_p1 <= bus.in_instruction;
            out_pc_p1    <= bus.in_pc;
        end else if (ld_out_skid) begin
            out_instr_p1 <= skid_instr_p0;
            out_pc_p1    <= skid_pc_p0;
        end
        if (ld_skid) begin
            skid_instr_p0 <= bus.in_instruction;
            skid_pc_p0    <= bus.in_pc;
        end
    end

    // Data registers carry no reset; the valid bit masks them to the bubble value.
    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = out_valid;
    assign bus.out_instruction = out_valid ? out_instr_p1 : NOP_INSTR;
    assign bus.out_pc          = out_valid ? out_pc_p1 : '0;

`ifdef IF_ID_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             stall_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // A flush counts only if it throws away a held entry or an entry being offered.
    assign stall_evt = out_valid & ~bus.out_ready & ~busywait;
    assign flush_evt = flush & ((out_valid & ~out_fire) | skid_valid | (bus.in_valid & in_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt) stall_q <= sat_inc(stall_q);
            if (flush_evt) flush_q <= sat_inc(flush_q);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed + randomized bench for if_id_skid_stage against a queue-based reference model.
module tb_if_id_skid_stage;
    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busywait = 1'b0;
    logic flush = 1'b0;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    int errors = 0;
    int checks = 0;

    logic [63:0] q[$];
    int m_stall = 0;
    int m_flush = 0;

    if_id_skid_stage_if #(.INSTR_W(32), .PC_W(32)) bus ();

    if_id_skid_stage #(
        .INSTR_W(32), .PC_W(32), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .busywait(busywait), .flush(flush), .bus(bus)
`ifdef IF_ID_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    task automatic check_outputs();
        logic [63:0] head;
        bit          vld;
        vld  = q.size() > 0;
        head = vld ? q[0] : {NOP, 32'h0};
        chk("in_ready", {63'b0, bus.in_ready}, {63'b0, (q.size() < 2) && !busywait});
        chk("out_valid", {63'b0, bus.out_valid}, {63'b0, vld});
        chk("out_instruction", {32'b0, bus.out_instruction}, {32'b0, head[63:32]});
        chk("out_pc", {32'b0, bus.out_pc}, {32'b0, head[31:0]});
`ifdef IF_ID_PERF_CNT_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        chk("flush_count", 64'(flush_count), 64'(m_flush));
`endif
    endtask

    // Queue holds the entries owned by the stage, oldest first; head is what decode sees.
    task automatic model_edge();
        bit m_rdy, m_vld, ofire, ifire, lost;
        m_rdy = (q.size() < 2) && !busywait;
        m_vld = q.size() > 0;
        ofire = m_vld && bus.out_ready && !busywait;
        ifire = bus.in_valid && m_rdy && !flush;
        lost  = (m_vld && !ofire) || (q.size() == 2) || (bus.in_valid && m_rdy);
        if (m_vld && !bus.out_ready && !busywait) m_stall = sat(m_stall);
        if (flush) begin
            if (lost) m_flush = sat(m_flush);
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back({bus.in_instruction, bus.in_pc});
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc, input logic rdy);
        bus.in_valid       = v;
        bus.in_instruction = instr;
        bus.in_pc          = pc;
        bus.out_ready      = rdy;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // 1: single transfer, one-cycle latency
        drive(1'b1, 32'h00500093, 32'h100, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        step();

        // 2: stream with a 2-cycle decode stall
        drive(1'b1, 32'hA0, 32'h0, 1'b1); step();
        drive(1'b1, 32'hA4, 32'h4, 1'b1); step();
        drive(1'b1, 32'hA8, 32'h8, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);  step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);  step();
        step();
        step();

        // 3: flush from SKID
        drive(1'b1, 32'hB0, 32'h20, 1'b0); step();
        drive(1'b1, 32'hB4, 32'h24, 1'b0); step();
        drive(1'b1, 32'hB8, 32'h28, 1'b0); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        chk("flush_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("flush_out_instr", {32'b0, bus.out_instruction}, {32'b0, NOP});
`ifdef IF_ID_PERF_CNT_EN
        chk("flush_count_one", 64'(flush_count), 64'd1);
`endif
        step();

        // 4: BUSYWAIT freeze with traffic offered
        drive(1'b1, 32'hC0, 32'h40, 1'b1); step();
        busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC4, 32'h44, 1'b1);
            step();
        end
        busywait = 1'b0;
        drive(1'b1, 32'hC8, 32'h48, 1'b1); step();
        drive(1'b1, 32'hCC, 32'h4C, 1'b1); step();

        // 5: asynchronous reset mid-cycle while FULL
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("async_rst_out_instr", {32'b0, bus.out_instruction}, {32'b0, NOP});
        chk("async_rst_out_pc", {32'b0, bus.out_pc}, 64'd0);
        rst = 1'b0;
        q.delete();
        m_stall = 0;
        m_flush = 0;
        @(posedge clk);
        #1;

        // 6: stall counter saturation
        drive(1'b1, 32'hD0, 32'h60, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (20) step();
`ifdef IF_ID_PERF_CNT_EN
        chk("stall_saturated", 64'(stall_cycles), 64'(CNT_MAX));
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            busywait = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 2) != 0));
            step();
        end
        busywait = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
